spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receive-side counterpart to the LIF neuron. It decodes the neuron's spike output back into numeric values. Two measurements are produced:
- a spike-rate count over a fixed window, delivered through a valid/ready output buffer;
- an inter-spike interval (ISI) measurement.

It sits downstream of the neuron, or on a spike line looped in from uio_in, and feeds uo_out/uio_out readback logic.

Parameters:
WINDOW_CYCLES, 256, length of the rate window in enabled clock cycles (>=2)
CNT_W, 8, width of rate count; saturating
ISI_W, 8, width of ISI counter; saturating
BURST_ISI, 4, ISI threshold for burst flag (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ena  in  1  enable; low freezes all counters and state
spike_i  in  1  spike level from neuron
rate_o  out  CNT_W  spike count of the last completed window
rate_valid_o  out  1  rate_o holds an unconsumed value
rate_ready_i  in  1  consumer accepts rate_o when high with rate_valid_o
rate_drop_o  out  1  sticky: a pending rate value was overwritten
isi_o  out  ISI_W  last measured inter-spike interval in cycles
isi_valid_o  out  1  one-cycle pulse when isi_o updates
burst_o  out  1  one-cycle burst pulse (optional feature)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. All logic updates on the rising clk edge only.
- Reset values:
  - all outputs 0, win_cnt=0, spk_cnt=0, spike_q=0;
  - ISI FSM in IDLE.
- Event detection:
  - event = spike_i & ~spike_q & ena.
  - spike_q <= spike_i every cycle, regardless of ena. A rising edge that occurs while ena is low is never counted later.
- Window:
  - win_cnt advances 0..WINDOW_CYCLES-1 on each ena cycle.
  - spk_cnt increments on each event, saturating at 2^CNT_W-1.
  - On the cycle win_cnt==WINDOW_CYCLES-1 with ena=1:
    - rate_o <= spk_cnt + event (saturating), rate_valid_o <= 1;
    - win_cnt <= 0, spk_cnt <= 0.
  - The first window closes on the WINDOW_CYCLES-th enabled cycle after reset.
- Output buffer:
  - Transfer occurs when rate_valid_o & rate_ready_i; rate_valid_o then clears next cycle unless a new window closes in that same cycle.
  - Window close while valid & !ready: rate_o is overwritten, valid stays 1, rate_drop_o <= 1 (sticky until rst).
  - Window close while valid & ready: old value is consumed, new value loaded, valid stays 1, no drop.
  - rate_o stays stable while rate_valid_o=1 and no window closes.
  - ready without valid has no effect.
- ISI FSM with states IDLE and MEASURE, counter isi_cnt:
  - IDLE, event: -> MEASURE, isi_cnt <= 1.
  - MEASURE, event: isi_o <= isi_cnt, isi_valid_o <= 1 for one cycle, isi_cnt <= 1, stay in MEASURE.
  - MEASURE, no event, ena: isi_cnt <= isi_cnt+1. On reaching 2^ISI_W-1, -> IDLE; no ISI is reported, and the next event restarts measurement.
  - Net effect: ISI equals the number of enabled cycles between consecutive events (adjacent-cycle edges are impossible, so minimum ISI is 2).
- ena low: nothing advances (win_cnt, spk_cnt, isi_cnt, FSM); isi_valid_o and burst_o are 0. The buffer handshake still operates.
- rst mid-window: partial count is discarded, pending rate is lost, rate_drop_o clears.

Optional Feature:
Macro SPIKE_BURST_DETECT_EN.
- Defined: burst_o pulses for one cycle, coincident with isi_valid_o, when the reported ISI is <= BURST_ISI.
- Undefined: burst_o is tied to 0 and no comparator is built.

Test Plan:
- WINDOW_CYCLES=16, ena=1, rate_ready_i=1; spike_i high for 1 cycle every 4 cycles starting at cycle 0 -> rate_o=4 with rate_valid_o set after cycle 15; consumed next cycle; repeats each window.
- Same spike train with rate_ready_i=0 for two windows -> rate_o=4, valid held, rate_drop_o=1 after the second close. Then ready=1 -> valid clears next cycle.
- spike_i edges at cycles 10 and 17 -> isi_valid_o pulses once with isi_o=7. With SPIKE_BURST_DETECT_EN defined and edges 3 apart, burst_o=1 alongside isi_o=3; undefined -> burst_o stays 0.
- ISI_W=4, edge at cycle 0, next edge at cycle 20 -> no isi_valid_o. Edge at 25 -> isi_o=5.
- spike_i held high for 10 cycles -> counts as 1 event. Edge while ena=0 -> not counted, window frozen.
- rst asserted mid-window with spk_cnt=3 and a pending rate -> all outputs 0 next cycle; the next window counts from 0.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: windowed spike-rate count behind a valid/ready buffer, plus an ISI measurement.
// Optional burst flag is built only when SPIKE_BURST_DETECT_EN is defined.
module spike_rate_decoder #(
    parameter int WINDOW_CYCLES = 256,
    parameter int CNT_W         = 8,
    parameter int ISI_W         = 8,
    parameter int BURST_ISI     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_i,
    output logic [CNT_W-1:0] rate_o,
    output logic             rate_valid_o,
    input  logic             rate_ready_i,
    output logic             rate_drop_o,
    output logic [ISI_W-1:0] isi_o,
    output logic             isi_valid_o,
    output logic             burst_o
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [ISI_W-1:0] ISI_MAX     = '1;
    localparam logic [ISI_W-1:0] ISI_PRE_MAX = ISI_MAX - ISI_W'(1);
    localparam logic [ISI_W-1:0] ISI_ONE     = ISI_W'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } isi_state_t;

    logic             r_spike_q;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spk_cnt;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_valid;
    logic             r_rate_drop;
    isi_state_t       r_isi_state;
    logic [ISI_W-1:0] r_isi_cnt;
    logic [ISI_W-1:0] r_isi;
    logic             r_isi_valid;

    logic             w_event;
    logic             w_win_close;
    logic [CNT_W-1:0] w_spk_inc;
    isi_state_t       w_isi_state_next;
    logic [ISI_W-1:0] w_isi_cnt_next;
    logic             w_isi_report;

    // A rising edge seen while disabled is absorbed by r_spike_q and never counted later.
    assign w_event     = spike_i & ~r_spike_q & ena;
    assign w_win_close = ena && (r_win_cnt == WIN_LAST);
    assign w_spk_inc   = (w_event && (r_spk_cnt != CNT_MAX)) ? r_spk_cnt + CNT_W'(1) : r_spk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_q <= 1'b0;
        end else begin
            r_spike_q <= spike_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_spk_cnt <= '0;
        end else if (ena) begin
            if (w_win_close) begin
                r_win_cnt <= '0;
                r_spk_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_spk_cnt <= w_spk_inc;
            end
        end
    end

    // A closing window always wins over a same-cycle transfer; drop only if the old value was never taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_rate_drop  <= 1'b0;
        end else if (w_win_close) begin
            r_rate       <= w_spk_inc;
            r_rate_valid <= 1'b1;
            if (r_rate_valid && !rate_ready_i) begin
                r_rate_drop <= 1'b1;
            end
        end else if (r_rate_valid && rate_ready_i) begin
            r_rate_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_isi_state <= S_IDLE;
            r_isi_cnt   <= '0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
        end else begin
            r_isi_state <= w_isi_state_next;
            r_isi_cnt   <= w_isi_cnt_next;
            r_isi_valid <= w_isi_report;
            if (w_isi_report) begin
                r_isi <= r_isi_cnt;
            end
        end
    end

    // Counter reaching its ceiling abandons the interval instead of reporting a saturated value.
    always_comb begin
        w_isi_state_next = r_isi_state;
        w_isi_cnt_next   = r_isi_cnt;
        w_isi_report     = 1'b0;
        case (r_isi_state)
            S_IDLE: begin
                if (w_event) begin
                    w_isi_state_next = S_MEASURE;
                    w_isi_cnt_next   = ISI_ONE;
                end
            end
            S_MEASURE: begin
                if (w_event) begin
                    w_isi_report   = 1'b1;
                    w_isi_cnt_next = ISI_ONE;
                end else if (ena) begin
                    if (r_isi_cnt >= ISI_PRE_MAX) begin
                        w_isi_cnt_next   = ISI_MAX;
                        w_isi_state_next = S_IDLE;
                    end else begin
                        w_isi_cnt_next = r_isi_cnt + ISI_ONE;
                    end
                end
            end
            default: begin
                w_isi_state_next = S_IDLE;
                w_isi_cnt_next   = '0;
            end
        endcase
    end

`ifdef SPIKE_BURST_DETECT_EN
    logic r_burst;
    logic w_is_burst;

    assign w_is_burst = (32'(r_isi_cnt) <= 32'(BURST_ISI));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst <= 1'b0;
        end else begin
            r_burst <= w_isi_report && w_is_burst;
        end
    end

    assign burst_o = r_burst;
`else
    assign burst_o = 1'b0 && (BURST_ISI >= 0);
`endif

    assign rate_o       = r_rate;
    assign rate_valid_o = r_rate_valid;
    assign rate_drop_o  = r_rate_drop;
    assign isi_o        = r_isi;
    assign isi_valid_o  = r_isi_valid;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random traffic against a
// behavioural model built from event indices and window counts.
module tb_spike_rate_decoder;

    localparam int WIN   = 16;
    localparam int CNT_W = 8;
    localparam int ISI_W = 4;
    localparam int BURST = 4;
    localparam int ISI_CEIL = (1 << ISI_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             spike_i = 1'b0;
    logic             rate_ready_i = 1'b0;
    logic [CNT_W-1:0] rate_o;
    logic             rate_valid_o;
    logic             rate_drop_o;
    logic [ISI_W-1:0] isi_o;
    logic             isi_valid_o;
    logic             burst_o;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_prev_spike, m_enabled_n, m_win_evts, m_win_pos;
    int m_rate, m_valid, m_drop;
    int m_isi, m_isi_v, m_burst;
    int m_last_evt, m_have_last;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WINDOW_CYCLES(WIN),
        .CNT_W        (CNT_W),
        .ISI_W        (ISI_W),
        .BURST_ISI    (BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spike_i     (spike_i),
        .rate_o      (rate_o),
        .rate_valid_o(rate_valid_o),
        .rate_ready_i(rate_ready_i),
        .rate_drop_o (rate_drop_o),
        .isi_o       (isi_o),
        .isi_valid_o (isi_valid_o),
        .burst_o     (burst_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_spike = 0; m_enabled_n = 0; m_win_evts = 0; m_win_pos = 0;
        m_rate = 0; m_valid = 0; m_drop = 0;
        m_isi = 0; m_isi_v = 0; m_burst = 0;
        m_last_evt = 0; m_have_last = 0;
    endtask

    // One enabled/disabled clock step evaluated from the rules: events, window close, buffer, ISI.
    task automatic model_step(input int r, input int s, input int e, input int rdy);
        int evt;
        int closing;
        int d;
        if (r != 0) begin
            model_reset();
            return;
        end
        evt = (s != 0 && m_prev_spike == 0 && e != 0) ? 1 : 0;
        m_prev_spike = s;
        m_isi_v = 0;
        m_burst = 0;
        closing = 0;
        if (e != 0) begin
            if (evt != 0) begin
                d = m_enabled_n - m_last_evt;
                if (m_have_last != 0 && d < ISI_CEIL) begin
                    m_isi = d;
                    m_isi_v = 1;
                    m_burst = (d <= BURST) ? 1 : 0;
                end
                m_last_evt = m_enabled_n;
                m_have_last = 1;
                m_win_evts++;
            end
            if (m_win_pos == WIN - 1) begin
                closing = 1;
                m_win_pos = 0;
            end else begin
                m_win_pos++;
            end
            m_enabled_n++;
        end
        if (closing != 0) begin
            if (m_valid != 0 && rdy == 0) m_drop = 1;
            m_rate = (m_win_evts > 255) ? 255 : m_win_evts;
            m_valid = 1;
            m_win_evts = 0;
        end else if (m_valid != 0 && rdy != 0) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input int r, input int s, input int e, input int rdy, input string ph);
        rst = (r != 0);
        spike_i = (s != 0);
        ena = (e != 0);
        rate_ready_i = (rdy != 0);
        @(posedge clk);
        model_step(r, s, e, rdy);
        #1;
        chk({ph, ".rate"}, 32'(rate_o), m_rate);
        chk({ph, ".rate_valid"}, 32'(rate_valid_o), m_valid);
        chk({ph, ".rate_drop"}, 32'(rate_drop_o), m_drop);
        chk({ph, ".isi_valid"}, 32'(isi_valid_o), m_isi_v);
        chk({ph, ".isi"}, 32'(isi_o), m_isi);
`ifdef SPIKE_BURST_DETECT_EN
        chk({ph, ".burst"}, 32'(burst_o), m_burst);
`else
        chk({ph, ".burst"}, 32'(burst_o), 0);
`endif
    endtask

    // Drives an edge exactly `gap` enabled cycles after the previous edge cycle.
    task automatic edge_after(input int gap, input string ph);
        for (int k = 0; k < gap - 1; k++) step(0, 0, 1, 1, ph);
        step(0, 1, 1, 1, ph);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, "reset");

        // Periodic train, consumer always ready: rate 4 each window
        for (int i = 0; i < 2 * WIN; i++) step(0, (i % 4 == 0) ? 1 : 0, 1, 1, "rate_ready");

        // Consumer stalls for two windows, then drains
        for (int i = 0; i < 2 * WIN; i++) step(0, (i % 4 == 0) ? 1 : 0, 1, 0, "rate_stall");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "rate_drain");

        // ISI intervals: normal, burst, timeout, restart, just-under and at the ceiling
        step(0, 1, 1, 1, "isi");
        edge_after(7, "isi7");
        edge_after(3, "isi3");
        edge_after(20, "isi_timeout");
        edge_after(5, "isi5");
        edge_after(14, "isi14");
        edge_after(15, "isi15");
        edge_after(2, "isi2");

        // Long high level counts once
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, "held");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "held_lo");

        // Edge during disable is lost; counters frozen
        step(0, 0, 0, 1, "ena_off");
        step(0, 1, 0, 1, "ena_off");
        step(0, 1, 0, 0, "ena_off");
        step(0, 1, 1, 1, "ena_back");
        step(0, 0, 1, 1, "ena_back");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(0, ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 7) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0, "random");
        end

        // Reset mid-window with a pending rate and a partial count
        for (int i = 0; i < WIN + 10; i++) step(0, (i % 4 == 0) ? 1 : 0, 1, 0, "pre_rst");
        step(1, 0, 1, 0, "mid_rst");
        for (int i = 0; i < WIN + 4; i++) step(0, (i % 4 == 1) ? 1 : 0, 1, 1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
